// File: rtl/x_bram18_sp_ctrl.sv
// Request-side controller for a 1K x 18 single-port block RAM: registers the RAM
// command, generates/checks per-byte parity, and runs a fill-all clear sequence.
`timescale 1ns/1ps
module x_bram18_sp_ctrl #(
    parameter logic [15:0] FILL_VALUE = 16'h0000,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [9:0]  req_addr_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic [1:0]  rsp_perr_o,
    input  logic        clr_start_i,
    output logic        clr_busy_o,
    output logic [9:0]  ram_addr_o,
    output logic [15:0] ram_di_o,
    output logic [1:0]  ram_dip_o,
    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic        ram_ssr_o,
    input  logic [15:0] ram_do_i,
    input  logic [1:0]  ram_dop_i
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic [1:0] par_gen(input logic [15:0] d);
        par_gen = {(^d[15:8]) ^ PARITY_ODD, (^d[7:0]) ^ PARITY_ODD};
    endfunction

    // A set bit means the stored parity disagrees with the data byte.
    function automatic logic [1:0] par_chk(input logic [15:0] d, input logic [1:0] p);
        par_chk = par_gen(d) ^ p;
    endfunction

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [15:0] ram_di_q, ram_di_d;
    logic [1:0]  ram_dip_q, ram_dip_d;
    logic        rd1_q, rd1_d;
    logic        rd2_q, rd2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_perr_q, rsp_perr_d;

    // Next-state logic for the sequencer, RAM command and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_di_d    = ram_di_q;
        ram_dip_d   = ram_dip_q;
        rd1_d       = 1'b0;
        rd2_d       = rd1_q;
        rsp_valid_d = rd2_q;
        rsp_data_d  = rsp_data_q;
        rsp_perr_d  = rsp_perr_q;

        // RAM DO for the tracked read is valid one edge after the RAM sampled it.
        if (rd2_q) begin
            rsp_data_d = ram_do_i;
            rsp_perr_d = par_chk(ram_do_i, ram_dop_i);
        end else begin
            rsp_data_d = rsp_data_q;
            rsp_perr_d = rsp_perr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (clr_start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 11'd0;
                end else if (req_valid_i) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = req_we_i;
                    ram_addr_d = req_addr_i;
                    ram_di_d   = req_data_i;
                    ram_dip_d  = par_gen(req_data_i);
                    rd1_d      = ~req_we_i;
                end else begin
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                ram_en_d   = 1'b1;
                ram_we_d   = 1'b1;
                ram_addr_d = cnt_q[9:0];
                ram_di_d   = FILL_VALUE;
                ram_dip_d  = par_gen(FILL_VALUE);
                cnt_d      = cnt_q + 11'd1;
                if (cnt_q == 11'd1023) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 11'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 10'd0;
            ram_di_q    <= 16'd0;
            ram_dip_q   <= 2'd0;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_perr_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_di_q    <= ram_di_d;
            ram_dip_q   <= ram_dip_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_perr_q  <= rsp_perr_d;
        end
    end

    // A clear request on the same edge wins over a pending request.
    assign req_ready_o = (state_q == ST_IDLE) & ~clr_start_i;
    assign clr_busy_o  = (state_q == ST_CLEAR);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_perr_o  = rsp_perr_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_di_o    = ram_di_q;
    assign ram_dip_o   = ram_dip_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_ssr_o   = 1'b0;

endmodule
